// File: rtl/unary_add_pkg.sv
// Shared definitions for the unary adder scheduler.
// Holds the scheduler state encoding, the default counter and job-length
// widths, the client index constants and a small index-to-grant helper.
// The scheduler top and its round-robin arbiter both import this package.
package unary_add_pkg;

    localparam int CNT_W_DEF = 12;
    localparam int LEN_W_DEF = 8;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FEED   = 3'd1,
        ST_DRAIN0 = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One-hot grant vector for a client index.
    function automatic logic [1:0] id_to_onehot(input logic id);
        return (id == CLIENT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/unary_add_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   req[1:0]  - request vector, bit i is client i
//   upd       - strobe: a job for client upd_id has just finished
//   upd_id    - index of the client that was just served
//   gnt[1:0]  - combinational one-hot grant (all zero when nothing requests)
//   gnt_id    - index matching gnt (CLIENT0 when no request)
// The priority pointer names the client that wins a tie; after reset it
// favours client 0 and after each served job it moves to the other client.
module rr_arb2
    import unary_add_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic prio_q;
    logic prio_d;

    // A lone requester always wins; only a tie consults the pointer.
    always_comb begin
        gnt    = 2'b00;
        gnt_id = CLIENT0;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                gnt_id = CLIENT0;
            end
            2'b10: begin
                gnt    = 2'b10;
                gnt_id = CLIENT1;
            end
            2'b11: begin
                gnt    = id_to_onehot(prio_q);
                gnt_id = prio_q;
            end
            default: begin
                gnt    = 2'b00;
                gnt_id = CLIENT0;
            end
        endcase
    end

    // The client just served loses priority to the other one.
    always_comb begin
        prio_d = prio_q;
        if (upd) begin
            prio_d = ~upd_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= CLIENT0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/unary_add_sched.sv
// unary_add_sched: shares one unary adder core between two clients.
// A job is granted round-robin, then the winner's serial A/B bits are fed to
// the core for len beats (accumulate), after which the core is drained and
// its unary count is counted back into a binary result.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req[1:0]            - per-client level request
//   len0, len1          - feed-beat count per client, sampled at grant
//   a0, b0, a1, b1      - client serial operand bits, consumed when beat=1
//   gnt[1:0]            - one-hot grant, held for the whole job
//   beat                - this cycle consumes the granted client's a/b
//   done                - one-cycle job-complete pulse
//   res                 - drained count, held until the next done
//   ovf                 - core carry seen during the job
//   res_id              - client index of the completed job
//   core_en, core_rw    - core enable and mode (0 accumulate, 1 drain)
//   core_a, core_b      - operand bits to the core
//   core_dout, core_c   - registered core drain bit and carry
module unary_add_sched
    import unary_add_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             a0,
    input  logic             b0,
    input  logic             a1,
    input  logic             b1,
    output logic [1:0]       gnt,
    output logic             beat,
    output logic             done,
    output logic [CNT_W-1:0] res,
    output logic             ovf,
    output logic             res_id,
    output logic             core_en,
    output logic             core_rw,
    output logic             core_a,
    output logic             core_b,
    input  logic             core_dout,
    input  logic             core_c
);

    state_t             state_q,   state_d;
    logic [1:0]         gnt_q,     gnt_d;
    logic               beat_q,    beat_d;
    logic               done_q,    done_d;
    logic [CNT_W-1:0]   res_q,     res_d;
    logic               ovf_q,     ovf_d;
    logic               res_id_q,  res_id_d;
    logic               core_en_q, core_en_d;
    logic               core_rw_q, core_rw_d;
    logic               win_id_q,  win_id_d;
    logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               ovf_acc_q, ovf_acc_d;

    logic [1:0]         arb_gnt;
    logic               arb_id;
    logic [LEN_W-1:0]   len_sel;

    // The pointer moves during the DONE cycle so the following IDLE cycle
    // already sees the served client demoted.
    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .upd    (state_q == ST_DONE),
        .upd_id (win_id_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    // Next-state and datapath logic. Every output is registered from a value
    // derived from state_d, so outputs line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        res_id_d  = res_id_q;
        win_id_d  = win_id_q;
        len_cnt_d = len_cnt_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        len_sel   = (arb_id == CLIENT1) ? len1 : len0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    win_id_d  = arb_id;
                    gnt_d     = arb_gnt;
                    len_cnt_d = len_sel;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    state_d   = (len_sel != '0) ? ST_FEED : ST_DRAIN0;
                end
            end
            ST_FEED: begin
                ovf_acc_d = ovf_acc_q | core_c;
                len_cnt_d = len_cnt_q - LEN_W'(1);
                if (len_cnt_q == LEN_W'(1)) begin
                    state_d = ST_DRAIN0;
                end
            end
            ST_DRAIN0: begin
                // The carry of the last feed beat only shows up here.
                ovf_acc_d = ovf_acc_q | core_c;
                state_d   = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (core_dout) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = ST_DONE;
                    res_d    = cnt_q;
                    ovf_d    = ovf_acc_q;
                    res_id_d = win_id_q;
                    gnt_d    = 2'b00;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase

        beat_d    = (state_d == ST_FEED);
        core_en_d = (state_d inside {ST_FEED, ST_DRAIN0, ST_DRAIN});
        core_rw_d = (state_d inside {ST_DRAIN0, ST_DRAIN});
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers; reset must match the core's own reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            beat_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            res_id_q  <= CLIENT0;
            core_en_q <= 1'b0;
            core_rw_q <= 1'b0;
            win_id_q  <= CLIENT0;
            len_cnt_q <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            res_id_q  <= res_id_d;
            core_en_q <= core_en_d;
            core_rw_q <= core_rw_d;
            win_id_q  <= win_id_d;
            len_cnt_q <= len_cnt_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
        end
    end

    // Operand bits pass straight through from the winner, gated to beats.
    assign core_a  = beat_q & ((win_id_q == CLIENT1) ? a1 : a0);
    assign core_b  = beat_q & ((win_id_q == CLIENT1) ? b1 : b0);

    assign gnt     = gnt_q;
    assign beat    = beat_q;
    assign done    = done_q;
    assign res     = res_q;
    assign ovf     = ovf_q;
    assign res_id  = res_id_q;
    assign core_en = core_en_q;
    assign core_rw = core_rw_q;

endmodule

// File: tb/tb_unary_add_sched.sv
// Directed testbench for unary_add_sched with a behavioural unary adder core.
// The core is built 4 bits wide so that wrap and the 15 boundary are reachable.
module tb_unary_add_sched;

    localparam int TB_CNT_W = 4;
    localparam int TB_LEN_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          req = 2'b00;
    logic [TB_LEN_W-1:0] len0 = '0;
    logic [TB_LEN_W-1:0] len1 = '0;
    logic                a0 = 1'b0, b0 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic [1:0]          gnt;
    logic                beat, done, ovf, res_id;
    logic [TB_CNT_W-1:0] res;
    logic                core_en, core_rw, core_a, core_b;
    logic                core_dout, core_c;
    logic [TB_CNT_W-1:0] core_cnt;

    int total = 0;
    int bad   = 0;

    unary_add_sched #(.CNT_W(TB_CNT_W), .LEN_W(TB_LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt       (gnt),
        .beat      (beat),
        .done      (done),
        .res       (res),
        .ovf       (ovf),
        .res_id    (res_id),
        .core_en   (core_en),
        .core_rw   (core_rw),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_dout (core_dout),
        .core_c    (core_c)
    );

    always #5 clk = ~clk;

    // Unary adder core: accumulate adds a+b with a registered carry; drain
    // emits one registered 1 per stored unit and then 0s.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_cnt  <= '0;
            core_dout <= 1'b0;
            core_c    <= 1'b0;
        end else if (!core_en) begin
            core_dout <= 1'b0;
            core_c    <= 1'b0;
        end else if (!core_rw) begin
            {core_c, core_cnt} <= {1'b0, core_cnt} + (TB_CNT_W+1)'(core_a) + (TB_CNT_W+1)'(core_b);
            core_dout <= 1'b0;
        end else begin
            core_c    <= 1'b0;
            core_dout <= (core_cnt != '0);
            if (core_cnt != '0) core_cnt <= core_cnt - TB_CNT_W'(1);
        end
    end

    // Counts every comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Presents one job and follows it to done. Latency counts the cycle
    // in which IDLE samples req as cycle 1 and the DONE cycle as the last.
    task automatic applyStimulus(input string tag, input logic [1:0] r, input logic hold,
                                 input logic [7:0] ln, input logic [15:0] av, input logic [15:0] bv,
                                 input int exp_id, input int exp_res, input int exp_ovf, input int exp_lat);
        int  n;
        int  k;
        logic got_done;
        logic gnt_seen;
        @(negedge clk);
        req = r; len0 = ln; len1 = ln;
        {a0, b0, a1, b1} = 4'b0000;
        n = 1; k = 0; got_done = 1'b0; gnt_seen = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (!gnt_seen && gnt != 2'b00) begin
                gnt_seen = 1'b1;
                checkOutput({tag, "_gnt"}, 32'(gnt), (exp_id == 1) ? 32'd2 : 32'd1);
                if (!hold) req = 2'b00;
            end
            if (beat) begin
                a0 = gnt[0] ? av[k] : ~av[k];
                b0 = gnt[0] ? bv[k] : ~bv[k];
                a1 = gnt[1] ? av[k] : ~av[k];
                b1 = gnt[1] ? bv[k] : ~bv[k];
                k++;
            end else begin
                {a0, b0, a1, b1} = 4'b0000;
            end
            if (done) got_done = 1'b1;
        end
        checkOutput({tag, "_done"}, 32'(got_done), 32'd1);
        checkOutput({tag, "_lat"}, n, exp_lat);
        checkOutput({tag, "_res"}, 32'(res), exp_res);
        checkOutput({tag, "_ovf"}, 32'(ovf), exp_ovf);
        checkOutput({tag, "_id"}, 32'(res_id), exp_id);
        checkOutput({tag, "_gnt_off"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_beats"}, k, 32'(ln));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int drain_seen;
        $display("[TB] start");
        #12;
        checkOutput("reset_ctl", 32'({gnt, beat, done, ovf, res_id, core_en, core_rw, core_a, core_b}), 32'd0);
        checkOutput("reset_res", 32'(res), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single job on client 0: sum 1+1, 1+0, 0+0 = 3.
        applyStimulus("single", 2'b01, 1'b0, 8'd3, 16'h0003, 16'h0001, 0, 3, 0, 10);
        @(posedge clk);
        #1;
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("res_held", 32'(res), 32'd3);
        repeat (2) @(negedge clk);

        // Zero length: feed skipped, 1 + 0 + 1 + 1 + 1 cycles.
        applyStimulus("zero", 2'b10, 1'b0, 8'd0, 16'h0000, 16'h0000, 1, 0, 0, 4);
        repeat (2) @(negedge clk);

        // Contention: later jobs start from the DONE cycle, one cycle more.
        applyStimulus("cont0", 2'b11, 1'b1, 8'd2, 16'h0003, 16'h0003, 0, 4, 0, 10);
        applyStimulus("cont1", 2'b11, 1'b1, 8'd2, 16'h0003, 16'h0003, 1, 4, 0, 11);
        applyStimulus("cont2", 2'b11, 1'b1, 8'd2, 16'h0003, 16'h0003, 0, 4, 0, 11);
        @(negedge clk);
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Overflow: 18 wraps to 2 in 4 bits.
        applyStimulus("ovf", 2'b01, 1'b0, 8'd9, 16'h01FF, 16'h01FF, 0, 2, 1, 15);
        repeat (2) @(negedge clk);

        // Boundary: 8 + 7 = 15 fits exactly.
        applyStimulus("edge15", 2'b01, 1'b0, 8'd8, 16'h00FF, 16'h007F, 0, 15, 0, 27);
        repeat (2) @(negedge clk);

        // Reset while draining a client 1 job of sum 6.
        @(negedge clk);
        req = 2'b10; len0 = 8'd3; len1 = 8'd3;
        a0 = 1'b0; b0 = 1'b0; a1 = 1'b1; b1 = 1'b1;
        drain_seen = 0;
        for (int c = 0; c < 50 && drain_seen < 3; c++) begin
            @(posedge clk);
            #1;
            if (gnt != 2'b00) req = 2'b00;
            if (core_rw) drain_seen++;
        end
        checkOutput("mid_reach", drain_seen, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ctl", 32'({gnt, beat, done, ovf, res_id, core_en, core_rw, core_a, core_b}), 32'd0);
        checkOutput("mid_rst_res", 32'(res), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        {a0, b0, a1, b1} = 4'b0000;
        repeat (2) @(negedge clk);

        // After reset the pointer favours client 0 again; sum 1 + 1 = 2.
        applyStimulus("post_rst", 2'b11, 1'b0, 8'd2, 16'h0001, 16'h0002, 0, 2, 0, 8);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
